// File: rtl/multi_register_bank_pkg.sv
// rtl/multi_register_bank_pkg.sv - shared FunSel encoding for the register bank
package multi_register_bank_pkg;

    localparam int FUNSEL_W = 3;

    typedef enum logic [FUNSEL_W-1:0] {
        FS_DEC  = 3'b000,
        FS_INC  = 3'b001,
        FS_LOAD = 3'b010,
        FS_CLR  = 3'b011,
        FS_LDLZ = 3'b100,
        FS_LDLK = 3'b101,
        FS_LDHK = 3'b110,
        FS_SEXT = 3'b111
    } funsel_t;

endpackage

// File: rtl/multi_register_bank_if.sv
// rtl/multi_register_bank_if.sv - write-control and read-port bundle of the register bank
interface multi_register_bank_if
    import multi_register_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 4
);
    localparam int SEL_W = $clog2(NREG);

    logic [NREG-1:0]  RegSel;
    funsel_t          FunSel;
    logic [WIDTH-1:0] I;
    logic [SEL_W-1:0] OutASel;
    logic [SEL_W-1:0] OutBSel;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;
    logic [NREG-1:0]  Wrap;

    modport master (
        output RegSel, FunSel, I, OutASel, OutBSel,
        input  OutA, OutB, Wrap
    );

    modport slave (
        input  RegSel, FunSel, I, OutASel, OutBSel,
        output OutA, OutB, Wrap
    );
endinterface

// File: rtl/multi_register_bank_register_cell.sv
// rtl/multi_register_bank_register_cell.sv - one WIDTH-bit register executing FunSel when enabled
module register_cell
    import multi_register_bank_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  funsel_t          FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q,
    output logic             Wrap
);
    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        case (FunSel)
            FS_DEC: begin
                q_next    = Q - 1'b1;
                wrap_next = (Q == '0);
            end
            FS_INC: begin
                q_next    = Q + 1'b1;
                wrap_next = &Q;
            end
            FS_LOAD: q_next = I;
            FS_CLR:  q_next = '0;
            FS_LDLZ: q_next = {{(WIDTH-H){1'b0}}, I[H-1:0]};
            FS_LDLK: q_next = {Q[WIDTH-1:H], I[H-1:0]};
            FS_LDHK: q_next = {I[H-1:0], Q[H-1:0]};
            FS_SEXT: q_next = {{(WIDTH-H){I[H-1]}}, I[H-1:0]};
        endcase
    end

    // Wrap is only rewritten when this register actually executes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Q    <= RESET_VAL;
            Wrap <= 1'b0;
        end else if (E) begin
            Q    <= q_next;
            Wrap <= wrap_next;
        end
    end
endmodule

// File: rtl/multi_register_bank.sv
// rtl/multi_register_bank.sv - NREG-entry register file with shared FunSel and two read ports
module multi_register_bank
    import multi_register_bank_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               NREG      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    multi_register_bank_if.slave bus
);
    logic [WIDTH-1:0] q [NREG];
    logic [NREG-1:0]  wrap;

    for (genvar k = 0; k < NREG; k++) begin : g_cell
        register_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (bus.RegSel[k]),
            .FunSel (bus.FunSel),
            .I      (bus.I),
            .Q      (q[k]),
            .Wrap   (wrap[k])
        );
    end

    // Reads see pre-edge state; there is deliberately no write bypass.
    assign bus.OutA = q[bus.OutASel];
    assign bus.OutB = q[bus.OutBSel];
    assign bus.Wrap = wrap;
endmodule

// File: tb/tb_multi_register_bank.sv
// tb/tb_multi_register_bank.sv - randomized and directed bench against a behavioural register model
module tb_multi_register_bank;
    import multi_register_bank_pkg::*;

    localparam int NR = 4;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    int mdl [NR];
    bit mwrap [NR];

    multi_register_bank_if #(.WIDTH(16), .NREG(NR)) bus ();

    multi_register_bank #(.WIDTH(16), .NREG(NR), .RESET_VAL(16'h0000)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #10 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_op(input int fs, input int q, input int d, output bit w);
        int lo;
        lo = d % 256;
        w  = 1'b0;
        case (fs)
            0: if (q == 0) begin w = 1'b1; return 65535; end else return q - 1;
            1: if (q == 65535) begin w = 1'b1; return 0; end else return q + 1;
            2: return d;
            3: return 0;
            4: return lo;
            5: return (q / 256) * 256 + lo;
            6: return lo * 256 + q % 256;
            default: return (lo >= 128) ? lo + 65280 : lo;
        endcase
    endfunction

    task automatic drive(input int mask, input int fs, input int data);
        bus.RegSel = mask[NR-1:0];
        bus.FunSel = funsel_t'(fs[2:0]);
        bus.I      = data[15:0];
    endtask

    task automatic verify_all(input string tag);
        for (int k = 0; k < NR; k++) begin
            bus.OutASel = k[1:0];
            bus.OutBSel = 2'(NR - 1 - k);
            #1;
            check({tag, "_A", $sformatf("%0d", k)}, 32'(bus.OutA), mdl[k]);
            check({tag, "_B", $sformatf("%0d", NR - 1 - k)}, 32'(bus.OutB), mdl[NR - 1 - k]);
            check({tag, "_W", $sformatf("%0d", k)}, 32'(bus.Wrap[k]), 32'(mwrap[k]));
        end
    endtask

    // Called just after a negedge with inputs set; advances one edge and checks.
    task automatic step(input string tag);
        int fs, d, m;
        bit w;
        m  = int'(bus.RegSel);
        fs = int'(bus.FunSel);
        d  = int'(bus.I);
        @(posedge Clock);
        if (!Reset) begin
            for (int k = 0; k < NR; k++) begin
                if (m[k]) begin
                    mdl[k]   = model_op(fs, mdl[k], d, w);
                    mwrap[k] = w;
                end
            end
        end
        #1;
        verify_all(tag);
        @(negedge Clock);
    endtask

    task automatic op(input string tag, input int mask, input int fs, input int data);
        drive(mask, fs, data);
        step(tag);
    endtask

    initial begin
        for (int k = 0; k < NR; k++) begin
            mdl[k] = 0;
            mwrap[k] = 1'b0;
        end
        drive(0, 0, 0);
        bus.OutASel = '0;
        bus.OutBSel = '0;
        #3;
        verify_all("rst_init");
        @(negedge Clock);
        Reset = 1'b0;

        op("ld_ffff", 4'b0001, 2, 16'hFFFF);
        op("inc_wrap", 4'b0001, 1, 0);
        check("inc_wrap_r0", 32'(dut.g_cell[0].u_cell.Q), 32'h0000);
        check("inc_wrap_w0", 32'(bus.Wrap[0]), 1);
        op("inc_nowrap", 4'b0001, 1, 0);
        check("inc_nowrap_w0", 32'(bus.Wrap[0]), 0);

        op("ld_r1", 4'b0010, 2, 16'h1234);
        op("ld_r2", 4'b0100, 2, 16'hABCD);
        op("ld_r3", 4'b1000, 2, 16'h5555);
        op("clr12", 4'b0110, 3, 16'hBEEF);

        op("ld_r3b", 4'b1000, 2, 16'h1234);
        op("ldlk", 4'b1000, 5, 16'h00EE);
        op("ldhk", 4'b1000, 6, 16'h0077);
        op("sext", 4'b1000, 7, 16'h0080);
        check("sext_r3", 32'(dut.g_cell[3].u_cell.Q), 32'hFF80);
        op("ldlz", 4'b1000, 4, 16'h0080);

        op("ld_r2_5", 4'b0100, 2, 16'h0005);
        drive(4'b0100, 1, 0);
        bus.OutASel = 2'd2;
        bus.OutBSel = 2'd2;
        #1;
        check("rd_same_A_pre", 32'(bus.OutA), 32'h0005);
        check("rd_same_B_pre", 32'(bus.OutB), 32'h0005);
        @(posedge Clock);
        mdl[2] = 6;
        mwrap[2] = 1'b0;
        #1;
        check("rd_same_A_post", 32'(bus.OutA), 32'h0006);
        check("rd_same_B_post", 32'(bus.OutB), 32'h0006);
        @(negedge Clock);

        op("clr_r1", 4'b0010, 3, 0);
        op("dec_wrap", 4'b0010, 0, 0);
        check("dec_wrap_r1", 32'(dut.g_cell[1].u_cell.Q), 32'hFFFF);
        for (int c = 0; c < 3; c++) op("hold", 4'b0000, 1, 16'h1111);

        // Asynchronous reset in the middle of a counting run.
        op("cnt0", 4'b1111, 1, 0);
        drive(4'b1111, 1, 0);
        @(posedge Clock);
        for (int k = 0; k < NR; k++) begin
            mdl[k] = (mdl[k] + 1) % 65536;
            mwrap[k] = (mdl[k] == 0);
        end
        #3;
        Reset = 1'b1;
        for (int k = 0; k < NR; k++) begin
            mdl[k] = 0;
            mwrap[k] = 1'b0;
        end
        #1;
        verify_all("rst_async");
        @(negedge Clock);
        step("rst_held");
        Reset = 1'b0;
        op("post_rst_inc", 4'b0001, 1, 0);

        for (int n = 0; n < 300; n++) begin
            drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
            if ($urandom_range(0, 3) == 0) bus.FunSel = funsel_t'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus.I = 16'hFFFF;
            bus.OutASel = 2'($urandom_range(0, NR - 1));
            bus.OutBSel = 2'($urandom_range(0, NR - 1));
            #1;
            check("rnd_pre_A", 32'(bus.OutA), mdl[bus.OutASel]);
            check("rnd_pre_B", 32'(bus.OutB), mdl[bus.OutBSel]);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
